// File: rtl/iob_eth_frame_sub.sv
// rtl/iob_eth_frame_sub.sv - IOb subordinate modelling the Ethernet core's MODER/BD/frame-buffer view
// One TX and one RX byte buffer; BD0 arms a TX frame, BD64 arms an RX capture.
module iob_eth_frame_sub #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 12,
    parameter int BUF_AW = 11
) (
    input  logic              clk_i,
    input  logic              arst_n_i,
    input  logic              iob_valid_i,
    input  logic [ADDR_W-1:0] iob_addr_i,
    input  logic [DATA_W-1:0] iob_wdata_i,
    input  logic [3:0]        iob_wstrb_i,
    output logic [DATA_W-1:0] iob_rdata_o,
    output logic              iob_ready_o,
    output logic              iob_rvalid_o,
    output logic [7:0]        tx_data_o,
    output logic              tx_valid_o,
    output logic              tx_last_o,
    input  logic              tx_ready_i,
    input  logic [7:0]        rx_data_i,
    input  logic              rx_valid_i,
    input  logic              rx_last_i,
    input  logic              rx_crc_err_i,
    output logic              rx_ready_o,
    output logic              tx_irq_o,
    output logic              rx_irq_o
);

    typedef enum logic [1:0] {TX_IDLE, TX_FETCH, TX_SEND, TX_DONE} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_RECV, RX_HOLD} rx_state_t;

    tx_state_t         tx_state;
    rx_state_t         rx_state;
    logic [1:0]        moder;
    logic [31:0]       bd0, bd64, bd0_next, bd64_next;
    logic [31:0]       bd_ram [0:255];
    logic [7:0]        tx_mem [0:(1<<BUF_AW)-1];
    logic [7:0]        rx_mem [0:(1<<BUF_AW)-1];
    logic [BUF_AW:0]   tx_wr_ptr, tx_rd_ptr, tx_rd_next, tx_level;
    logic [15:0]       tx_len, tx_cnt;
    logic [BUF_AW-1:0] rx_cnt, rx_rd_ptr, rx_nbytes;

    logic [9:0] word_idx;
    logic [7:0] bd_idx;
    logic       sel_moder, sel_nbytes, sel_frame, sel_bd;
    logic       wr_req, rd_req, wr_acc, rd_acc, push, pop_ok;
    logic       bd0_wr, bd64_wr, ram_wr, tx_full, tx_start, tx_hw_clr;
    logic       rx_acc, rx_full, rx_done, rx_rearm;
    logic [1:0] unused_addr;

    function automatic logic [31:0] lane_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                               input logic [3:0] strb);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = strb[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
        return r;
    endfunction

    assign unused_addr = iob_addr_i[1:0];
    assign word_idx    = iob_addr_i[11:2];
    assign bd_idx      = word_idx[7:0];
    assign sel_moder   = word_idx == 10'd0;
    assign sel_nbytes  = word_idx == 10'd1;
    assign sel_frame   = word_idx == 10'd2;
    assign sel_bd      = word_idx[9:8] == 2'b01;

    assign tx_level    = tx_wr_ptr - tx_rd_ptr;
    assign tx_rd_next  = tx_rd_ptr + 1'b1;
    assign tx_full     = tx_level[BUF_AW];

    assign wr_req      = iob_valid_i && (iob_wstrb_i != 4'b0);
    assign rd_req      = iob_valid_i && (iob_wstrb_i == 4'b0);
    // The only back-pressure: a frame-word push into a full TX buffer.
    assign iob_ready_o = arst_n_i && !(wr_req && sel_frame && tx_full);
    assign wr_acc      = wr_req && iob_ready_o;
    assign rd_acc      = rd_req && iob_ready_o;
    assign push        = wr_acc && sel_frame && iob_wstrb_i[0];
    assign pop_ok      = rd_acc && sel_frame && (rx_state == RX_HOLD) && (rx_rd_ptr < rx_nbytes);
    assign bd0_wr      = wr_acc && sel_bd && (bd_idx == 8'd0);
    assign bd64_wr     = wr_acc && sel_bd && (bd_idx == 8'd64);
    assign ram_wr      = wr_acc && sel_bd && (bd_idx != 8'd0) && (bd_idx != 8'd64);

    assign tx_start  = moder[1] && bd0[15] && (bd0[31:16] != 16'd0) &&
                       ({{(15-BUF_AW){1'b0}}, tx_level} >= bd0[31:16]);
    assign tx_hw_clr = ((tx_state == TX_SEND) && tx_valid_o && tx_ready_i && tx_last_o) ||
                       ((tx_state == TX_IDLE) && moder[1] && bd0[15] && (bd0[31:16] == 16'd0));

    assign rx_acc   = (rx_state == RX_RECV) && rx_valid_i && rx_ready_o;
    assign rx_full  = &rx_cnt;
    assign rx_done  = rx_acc && rx_last_i;
    assign rx_rearm = bd64_wr && iob_wstrb_i[1] && iob_wdata_i[15];

    // Hardware clears of the READY/EMPTY bit override a simultaneous CPU write on bit15 only.
    always_comb begin
        bd0_next = bd0_wr ? lane_merge(bd0, iob_wdata_i, iob_wstrb_i) : bd0;
        if (tx_hw_clr) bd0_next[15] = 1'b0;
        bd64_next = bd64;
        if (rx_done) bd64_next[1] = rx_crc_err_i;
        if (bd64_wr) bd64_next = lane_merge(bd64_next, iob_wdata_i, iob_wstrb_i);
        if (rx_done) bd64_next[15] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (push) tx_mem[tx_wr_ptr[BUF_AW-1:0]] <= iob_wdata_i[7:0];
        if (rx_acc && !rx_full) rx_mem[rx_cnt] <= rx_data_i;
        if (ram_wr)
            for (int i = 0; i < 4; i++)
                if (iob_wstrb_i[i]) bd_ram[bd_idx][8*i +: 8] <= iob_wdata_i[8*i +: 8];
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            iob_rvalid_o <= 1'b0;
            iob_rdata_o  <= '0;
            moder        <= 2'b0;
        end else begin
            iob_rvalid_o <= rd_acc;
            if (wr_acc && sel_moder && iob_wstrb_i[0]) moder <= iob_wdata_i[1:0];
            if (rd_acc) begin
                if (sel_moder)
                    iob_rdata_o <= {{(DATA_W-2){1'b0}}, moder};
                else if (sel_nbytes)
                    iob_rdata_o <= (rx_state == RX_HOLD) ? {{(DATA_W-BUF_AW){1'b0}}, rx_nbytes} : '0;
                else if (sel_frame)
                    iob_rdata_o <= pop_ok ? {{(DATA_W-8){1'b0}}, rx_mem[rx_rd_ptr]} : '0;
                else if (sel_bd)
                    iob_rdata_o <= (bd_idx == 8'd0) ? bd0 : (bd_idx == 8'd64) ? bd64 : bd_ram[bd_idx];
                else
                    iob_rdata_o <= '0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            tx_state   <= TX_IDLE;
            tx_wr_ptr  <= '0;
            tx_rd_ptr  <= '0;
            tx_len     <= 16'd0;
            tx_cnt     <= 16'd0;
            tx_data_o  <= 8'd0;
            tx_valid_o <= 1'b0;
            tx_last_o  <= 1'b0;
            tx_irq_o   <= 1'b0;
            bd0        <= 32'd0;
        end else begin
            bd0      <= bd0_next;
            tx_irq_o <= 1'b0;
            if (push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
            case (tx_state)
                TX_IDLE: if (tx_start) begin
                    tx_len   <= bd0[31:16];
                    tx_state <= TX_FETCH;
                end
                TX_FETCH: begin
                    tx_data_o  <= tx_mem[tx_rd_ptr[BUF_AW-1:0]];
                    tx_valid_o <= 1'b1;
                    tx_last_o  <= tx_len == 16'd1;
                    tx_cnt     <= 16'd0;
                    tx_state   <= TX_SEND;
                end
                TX_SEND: if (tx_valid_o && tx_ready_i) begin
                    tx_rd_ptr <= tx_rd_next;
                    if (tx_last_o) begin
                        tx_valid_o <= 1'b0;
                        tx_last_o  <= 1'b0;
                        tx_irq_o   <= bd0[14];
                        tx_state   <= TX_DONE;
                    end else begin
                        // Prefetch the following byte so a ready stream moves one byte per cycle.
                        tx_data_o <= tx_mem[tx_rd_next[BUF_AW-1:0]];
                        tx_cnt    <= tx_cnt + 16'd1;
                        tx_last_o <= (tx_cnt + 16'd2) == tx_len;
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            rx_state   <= RX_IDLE;
            rx_cnt     <= '0;
            rx_rd_ptr  <= '0;
            rx_nbytes  <= '0;
            rx_ready_o <= 1'b0;
            rx_irq_o   <= 1'b0;
            bd64       <= 32'd0;
        end else begin
            bd64     <= bd64_next;
            rx_irq_o <= 1'b0;
            case (rx_state)
                RX_IDLE: if (moder[0] && bd64[15]) begin
                    rx_ready_o <= 1'b1;
                    rx_state   <= RX_RECV;
                end
                RX_RECV: if (rx_acc) begin
                    if (!rx_full) rx_cnt <= rx_cnt + 1'b1;
                    if (rx_last_i) begin
                        rx_nbytes  <= rx_full ? rx_cnt : rx_cnt + 1'b1;
                        rx_ready_o <= 1'b0;
                        rx_irq_o   <= bd64[14];
                        rx_state   <= RX_HOLD;
                    end
                end
                RX_HOLD: if (rx_rearm) begin
                    rx_nbytes <= '0;
                    rx_rd_ptr <= '0;
                    rx_cnt    <= '0;
                    rx_state  <= RX_IDLE;
                end else if (pop_ok) begin
                    rx_rd_ptr <= rx_rd_ptr + 1'b1;
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iob_eth_frame_sub.sv
// tb/tb_iob_eth_frame_sub.sv - directed bench for iob_eth_frame_sub
module tb_iob_eth_frame_sub;

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic        valid = 1'b0;
    logic [11:0] addr = 12'd0;
    logic [31:0] wdata = 32'd0;
    logic [3:0]  wstrb = 4'd0;
    logic [31:0] iob_rdata_o;
    logic        iob_ready_o, iob_rvalid_o;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o, tx_last_o;
    logic        tx_ready = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0, rx_last = 1'b0, rx_crc = 1'b0;
    logic        rx_ready_o, tx_irq_o, rx_irq_o;

    int n_checks = 0;
    int n_fail = 0;

    iob_eth_frame_sub #(.DATA_W(32), .ADDR_W(12), .BUF_AW(11)) dut (
        .clk_i(clk), .arst_n_i(arst_n),
        .iob_valid_i(valid), .iob_addr_i(addr), .iob_wdata_i(wdata), .iob_wstrb_i(wstrb),
        .iob_rdata_o(iob_rdata_o), .iob_ready_o(iob_ready_o), .iob_rvalid_o(iob_rvalid_o),
        .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_last_o(tx_last_o), .tx_ready_i(tx_ready),
        .rx_data_i(rx_data), .rx_valid_i(rx_valid), .rx_last_i(rx_last), .rx_crc_err_i(rx_crc),
        .rx_ready_o(rx_ready_o), .tx_irq_o(tx_irq_o), .rx_irq_o(rx_irq_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
        int n;
        n = 0;
        valid = 1'b1; addr = a; wdata = d; wstrb = s;
        #1;
        while (!iob_ready_o && n < 4000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 4000) check("write_timeout_ready", {31'd0, iob_ready_o}, 32'd1);
        @(negedge clk);
        valid = 1'b0; wstrb = 4'd0;
    endtask

    task automatic bus_read(input logic [11:0] a, output logic [31:0] d);
        valid = 1'b1; addr = a; wstrb = 4'd0;
        @(negedge clk);
        check("rvalid", {31'd0, iob_rvalid_o}, 32'd1);
        d = iob_rdata_o;
        valid = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [11:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(a, d);
        check(tag, d, exp);
    endtask

    task automatic rx_send(input int n, input logic [7:0] seed, input logic crc);
        for (int i = 0; i < n; i++) begin
            int w;
            w = 0;
            rx_valid = 1'b1;
            rx_data  = seed + i[7:0];
            rx_last  = (i == n - 1);
            rx_crc   = crc && (i == n - 1);
            while (!rx_ready_o && w < 100) begin
                @(negedge clk);
                w++;
            end
            @(negedge clk);
        end
        rx_valid = 1'b0; rx_last = 1'b0; rx_crc = 1'b0;
    endtask

    task automatic tx_collect(input int n, input logic [7:0] base, input bit toggle);
        int got, irqs, data_err, last_err, stall_err;
        logic pv, pr;
        logic [7:0] pd, expb;
        got = 0; irqs = 0; data_err = 0; last_err = 0; stall_err = 0;
        pv = 1'b0; pr = 1'b1; pd = 8'd0;
        for (int c = 0; c < n * 3 + 20; c++) begin
            tx_ready = toggle ? c[0] : 1'b1;
            if (tx_irq_o) irqs++;
            if (pv && !pr && tx_data_o !== pd) stall_err++;
            if (tx_valid_o && tx_ready) begin
                expb = base + got[7:0];
                if (tx_data_o !== expb) data_err++;
                if (tx_last_o !== (got == n - 1)) last_err++;
                got++;
            end
            pv = tx_valid_o; pr = tx_ready; pd = tx_data_o;
            @(negedge clk);
        end
        tx_ready = 1'b1;
        check("tx_byte_count", got, n);
        check("tx_data_errors", data_err, 0);
        check("tx_last_errors", last_err, 0);
        check("tx_stall_errors", stall_err, 0);
        check("tx_irq_pulses", irqs, 1);
    endtask

    initial begin
        logic [31:0] d;
        repeat (3) @(negedge clk);
        check("rst_ready", {31'd0, iob_ready_o}, 32'd0);
        check("rst_rvalid", {31'd0, iob_rvalid_o}, 32'd0);
        check("rst_rdata", iob_rdata_o, 32'd0);
        check("rst_tx", {29'd0, tx_valid_o, tx_last_o, tx_irq_o}, 32'd0);
        check("rst_rx", {30'd0, rx_ready_o, rx_irq_o}, 32'd0);
        arst_n = 1'b1;
        @(negedge clk);
        check("ready_idle", {31'd0, iob_ready_o}, 32'd1);

        read_check("moder_rst", 12'h000, 32'd0);
        read_check("nbytes_rst", 12'h004, 32'd0);
        read_check("bd0_rst", 12'h400, 32'd0);
        read_check("bd64_rst", 12'h500, 32'd0);
        bus_write(12'h000, 32'hFFFF_FFFF, 4'hF);
        read_check("moder_mask", 12'h000, 32'h3);
        bus_write(12'h000, 32'h3, 4'hF);
        read_check("moder_rw", 12'h000, 32'h3);
        bus_write(12'h00C, 32'hFFFF_FFFF, 4'hF);
        read_check("unmapped", 12'h00C, 32'd0);
        bus_write(12'h404, 32'h1234_5678, 4'hF);
        bus_write(12'h404, 32'hAABB_CCDD, 4'b0010);
        read_check("bd_ram_strobe", 12'h404, 32'h1234_CC78);
        @(negedge clk);
        check("rvalid_idle", {31'd0, iob_rvalid_o}, 32'd0);

        // TX frame, MAC always ready
        tx_ready = 1'b1;
        for (int i = 0; i < 60; i++) bus_write(12'h008, i, 4'h1);
        bus_write(12'h400, 32'h003C_C800, 4'hF);
        check("tx_lat0", {31'd0, tx_valid_o}, 32'd0);
        @(negedge clk);
        check("tx_lat1", {31'd0, tx_valid_o}, 32'd0);
        @(negedge clk);
        check("tx_lat2", {31'd0, tx_valid_o}, 32'd1);
        tx_collect(60, 8'h00, 1'b0);
        read_check("bd0_done1", 12'h400, 32'h003C_4800);

        // TX frame with a stalling MAC
        for (int i = 0; i < 60; i++) bus_write(12'h008, 32'h40 + i, 4'h1);
        bus_write(12'h400, 32'h003C_C800, 4'hF);
        tx_collect(60, 8'h40, 1'b1);
        read_check("bd0_done2", 12'h400, 32'h003C_4800);

        // RX frame, good CRC
        bus_write(12'h500, 32'h0000_C000, 4'hF);
        rx_send(64, 8'h80, 1'b0);
        check("rx_irq1", {31'd0, rx_irq_o}, 32'd1);
        @(negedge clk);
        check("rx_irq1_pulse", {31'd0, rx_irq_o}, 32'd0);
        read_check("rx_nbytes1", 12'h004, 32'd64);
        read_check("bd64_done1", 12'h500, 32'h0000_4000);
        for (int i = 0; i < 64; i++) read_check("rx_pop", 12'h008, 32'h80 + i);
        read_check("rx_pop_past_end", 12'h008, 32'd0);
        read_check("rx_nbytes_kept", 12'h004, 32'd64);

        // RX frame, CRC error
        bus_write(12'h500, 32'h0000_C000, 4'hF);
        read_check("rx_nbytes_rearm", 12'h004, 32'd0);
        rx_send(8, 8'h10, 1'b1);
        check("rx_irq2", {31'd0, rx_irq_o}, 32'd1);
        read_check("bd64_crc", 12'h500, 32'h0000_4002);
        read_check("rx_nbytes2", 12'h004, 32'd8);
        read_check("rx_pop2", 12'h008, 32'h10);

        // Re-arm and capture a new frame
        bus_write(12'h500, 32'h0000_C000, 4'hF);
        read_check("rx_nbytes_rearm2", 12'h004, 32'd0);
        rx_send(3, 8'h20, 1'b0);
        read_check("rx_nbytes3", 12'h004, 32'd3);
        read_check("bd64_done3", 12'h500, 32'h0000_4000);
        read_check("rx_pop3", 12'h008, 32'h20);

        // Full TX buffer back-pressure
        tx_ready = 1'b0;
        for (int i = 0; i < 2048; i++) bus_write(12'h008, i, 4'h1);
        bus_write(12'h400, 32'h0004_C000, 4'hF);
        fork
            bus_write(12'h008, 32'h55, 4'h1);
            begin
                repeat (6) @(negedge clk);
                check("ready_full_stall", {31'd0, iob_ready_o}, 32'd0);
                tx_ready = 1'b1;
            end
        join
        repeat (6) @(negedge clk);
        read_check("bd0_done_full", 12'h400, 32'h0004_4000);

        // Reset in the middle of a TX frame
        bus_write(12'h400, 32'h0064_C000, 4'hF);
        repeat (8) @(negedge clk);
        check("tx_midframe", {31'd0, tx_valid_o}, 32'd1);
        #2 arst_n = 1'b0;
        #1;
        check("async_rst_tx", {29'd0, tx_valid_o, tx_last_o, tx_irq_o}, 32'd0);
        check("async_rst_bus", {30'd0, iob_ready_o, iob_rvalid_o}, 32'd0);
        check("async_rst_rx", {30'd0, rx_ready_o, rx_irq_o}, 32'd0);
        @(negedge clk);
        arst_n = 1'b1;
        @(negedge clk);
        read_check("bd0_after_rst", 12'h400, 32'd0);
        read_check("moder_after_rst", 12'h000, 32'd0);
        check("tx_idle_after_rst", {30'd0, tx_valid_o, tx_last_o}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/iob_eth_frame_sub.md
# iob_eth_frame_sub

Synthesizable IOb-native subordinate that terminates the manager-side accesses the Ethernet driver issues: MODER, RX_NBYTES, FRAME_WORD and the buffer-descriptor (BD) memory. It holds one TX and one RX byte buffer, streams TX frames out to the MAC side when BD0 is armed, and captures one RX frame into its buffer when BD64 is marked empty. It sits between the CPU/testbench IOb bus and the MAC byte interfaces. It replaces the full core in bus-level and frame-level simulation.

## Interface
- DATA_W, 32, IOb data width (fixed 32)
- ADDR_W, 12, IOb byte-address width
- BUF_AW, 11, log2 of TX/RX buffer depth in bytes (2048)
- clk_i  in  1  clock
- arst_n_i  in  1  reset; asynchronous, active-low
- iob_valid_i  in  1  request valid
- iob_addr_i  in  ADDR_W  byte address; bits [1:0] ignored
- iob_wdata_i  in  DATA_W  write data
- iob_wstrb_i  in  4  byte strobes; 0 means read
- iob_rdata_o  out  DATA_W  read data, valid with rvalid
- iob_ready_o  out  1  request accepted
- iob_rvalid_o  out  1  read data valid
- tx_data_o  out  8  TX byte
- tx_valid_o  out  1  TX byte valid
- tx_last_o  out  1  last byte of frame
- tx_ready_i  in  1  MAC accepts TX byte
- rx_data_i  in  8  RX byte
- rx_valid_i  in  1  RX byte valid
- rx_last_i  in  1  last RX byte
- rx_crc_err_i  in  1  CRC error, sampled with rx_last_i
- rx_ready_o  out  1  block accepts RX byte
- tx_irq_o  out  1  one-cycle pulse, TX frame done
- rx_irq_o  out  1  one-cycle pulse, RX frame captured

## Operation
- Map (byte addr): 0x000 MODER RW (bit0 RXEN, bit1 TXEN, others read 0); 0x004 RX_NBYTES RO [10:0]; 0x008 FRAME_WORD (write pushes wdata[7:0] into TX buffer if wstrb[0]; read pops one RX byte into rdata[7:0]); 0x400–0x7FF BD memory, 256 words, word i at 0x400+4i. Other addresses: writes dropped, reads return 0.
- BD word layout (even index): [31:16] LEN, bit15 READY/EMPTY, bit14 IRQ, bit13 WRAP, bit12 PAD, bit11 CRC, bit1 RX CRC error. BD0 and BD64 are flops; the rest are single-port RAM. Byte strobes apply per lane.
- TX FSM: IDLE → SEND when TXEN && BD0[15] && tx_level ≥ LEN && LEN≠0. SEND presents bytes; a byte retires on tx_valid_o && tx_ready_i. tx_last_o is high with byte LEN. → DONE clears BD0[15] and pulses tx_irq_o if BD0[14]. → IDLE. LEN=0 with READY set: clear READY in one cycle, no bytes, no irq. Extra buffered bytes stay for the next frame.
- RX FSM: IDLE → RECV when RXEN && BD64[15]. rx_ready_o=1 only in RECV. Each accepted byte is written; the count saturates at 2^BUF_AW−1, and further bytes are accepted and discarded. On an accepted rx_last_i: latch RX_NBYTES = count, clear BD64[15], set BD64[1]=rx_crc_err_i, pulse rx_irq_o if BD64[14] → HOLD.
- In HOLD, FRAME_WORD reads pop in order. A read past RX_NBYTES returns 0 and does not move the pointer.
- A software write setting BD64[15] in HOLD clears RX_NBYTES, the read pointer and the count → IDLE.
- RX_NBYTES reads 0 outside HOLD.
- Priority: a hardware clear of BD0[15]/BD64[15] in the same cycle as a CPU write to that word wins on bit15 only. The CPU write applies to all other bits.

## Timing
- Reset values: iob_ready_o=0, iob_rvalid_o=0, iob_rdata_o=0, tx_valid_o=0, tx_last_o=0, rx_ready_o=0, irqs=0, MODER=0, BD0=BD64=0, buffers empty, FSMs IDLE. RAM BD contents are undefined after reset.
- iob_ready_o is combinational and equals 1, except when a FRAME_WORD write targets a full TX buffer; the manager then holds the request until ready.
- Reads: iob_rvalid_o and iob_rdata_o are registered, one cycle after the accepted read. Back-to-back reads are allowed, one per cycle.
- Writes take effect on the accepting edge. The TX FSM sees BD0 changes the next cycle.
- TX: first tx_valid_o comes 2 cycles after the start condition (buffer read latency). Throughput is one byte per cycle while tx_ready_i=1. tx_data_o is stable while tx_valid_o && !tx_ready_i. tx_irq_o follows the last handshake by 1 cycle.
- RX: rx_irq_o and RX_NBYTES update 1 cycle after the last handshake.
- Reset mid-frame aborts immediately, with no partial tx_last_o or irq.

## Test plan
- Reset, then read MODER, RX_NBYTES and BD0 → all 0. Write MODER=0x3, read back → 0x3 one cycle after ready.
- Push 60 bytes 0x00..0x3B, write BD0=0x003C_C800 with tx_ready_i=1 → 60 bytes on tx_data_o in order, tx_last_o on 0x3B, tx_irq_o pulse, BD0 reads 0x003C_4800.
- Repeat with tx_ready_i toggling 1/0 → same bytes, no drops or duplicates, tx_data_o held while stalled.
- BD64=0x0000_C000, RXEN; stream 64 bytes with rx_last_i and rx_crc_err_i=0 → rx_irq_o, RX_NBYTES=64, BD64 bit15=0 bit1=0; 64 FRAME_WORD reads return the bytes, 65th read returns 0.
- Same flow with rx_crc_err_i=1 → BD64 bit1=1. Rewrite BD64 with bit15 set → RX_NBYTES=0 and a new frame is accepted.
- Fill TX buffer to 2048 bytes; the next FRAME_WORD write stalls with ready=0 until a TX frame drains. Assert arst_n_i=0 mid-TX frame → outputs return to reset values asynchronously.
